outgoing_request_buffer_qos: RTL and testbench

- Parametrised successor to the outgoing AR FIFO. Sits between ar_ordering_unit and the AXI slave.
- Holds up to DEPTH AR requests in an age-ordered, compacting queue.
- Issues either strictly in order (MODE=0) or by highest QoS (MODE=1), with starvation protection.
- Never reorders two requests that share an ID.
- Adds occupancy and almost-full status for upstream throttling.

---
 rtl/outgoing_request_buffer_qos_pkg.sv | 14 +
 rtl/outgoing_request_buffer_qos_if.sv | 30 +++
 rtl/outgoing_request_buffer_qos_select.sv | 60 ++++++
 rtl/outgoing_request_buffer_qos.sv | 176 +++++++++++++++++
 tb/tb_outgoing_request_buffer_qos.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/outgoing_request_buffer_qos_pkg.sv
// Shared constants and helpers for the outgoing AR request buffer with QoS issue.
// The entry struct lives in the top module because its field widths follow
// that module's parameters.
package ar_buf_pkg;

  localparam int MODE_FIFO = 0;
  localparam int MODE_QOS  = 1;

  // Index width for an array of n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/outgoing_request_buffer_qos_if.sv
// AXI AR channel bundle: valid/ready handshake plus the request payload.
interface ar_if #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int SIZE_WIDTH  = 3,
  parameter int BURST_WIDTH = 2,
  parameter int QOS_WIDTH   = 4
) ();

  logic                   valid;
  logic                   ready;
  logic [ID_WIDTH-1:0]    id;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [LEN_WIDTH-1:0]   len;
  logic [SIZE_WIDTH-1:0]  size;
  logic [BURST_WIDTH-1:0] burst;
  logic [QOS_WIDTH-1:0]   qos;

  modport sender (
    output valid, id, addr, len, size, burst, qos,
    input  ready
  );

  modport receiver (
    input  valid, id, addr, len, size, burst, qos,
    output ready
  );

endinterface

// File: rtl/outgoing_request_buffer_qos_select.sv
// Combinational issue selector: same-ID eligibility filter followed by a
// max-QoS search with ties resolved toward the oldest (lowest) index.
module ar_qos_select
  import ar_buf_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ID_WIDTH  = 4,
  parameter int QOS_WIDTH = 4,
  parameter int MODE      = MODE_QOS,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int IDX_W    = clog2_min1(DEPTH)
) (
  input  logic [DEPTH-1:0][ID_WIDTH-1:0]  ids,
  input  logic [DEPTH-1:0][QOS_WIDTH-1:0] qos,
  input  logic [CNT_W-1:0]                count,
  input  logic                            force_head,
  output logic [IDX_W-1:0]                sel,
  output logic                            starve_force
);

  logic [DEPTH-1:0]     eligible;
  logic [IDX_W-1:0]     best_idx;
  logic [QOS_WIDTH-1:0] best_qos;
  logic                 found;

  // An entry may issue only if it is valid and no older entry shares its ID.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = (i < int'(count));
      for (int j = 0; j < i; j++) begin
        if (ids[j] == ids[i]) begin
          eligible[i] = 1'b0;
        end
      end
    end
  end

  // Scan oldest to youngest; a strictly greater QoS is needed to displace the
  // current pick, so ties stay with the older entry. FIFO mode or a starved
  // head collapses the choice to index 0.
  always_comb begin
    best_idx = '0;
    best_qos = '0;
    found    = 1'b0;
    if (MODE == MODE_QOS && !force_head) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (eligible[i] && (!found || qos[i] > best_qos)) begin
          found    = 1'b1;
          best_qos = qos[i];
          best_idx = IDX_W'(i);
        end
      end
    end
  end

  assign sel          = best_idx;
  assign starve_force = (MODE == MODE_QOS) && force_head && (count != '0);

endmodule

// File: rtl/outgoing_request_buffer_qos.sv
// Outgoing AR request buffer: age-ordered compacting queue that issues in
// order or by QoS, keeps same-ID requests in order, bounds head starvation and
// holds the presented request stable until the slave accepts it.
module outgoing_request_buffer_qos
  import ar_buf_pkg::*;
#(
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int BURST_WIDTH  = 2,
  parameter int QOS_WIDTH    = 4,
  parameter int DEPTH        = 8,
  parameter int MODE         = MODE_QOS,
  parameter int STARVE_LIMIT = 4,
  parameter int AFULL_THRESH = 6,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  ar_if.receiver           ar_in,
  ar_if.sender             ar_out,
  output logic [CNT_W-1:0] occupancy,
  output logic             almost_full,
  output logic             starve_force
);

  localparam int IDX_W  = clog2_min1(DEPTH);
  localparam int SKIP_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX  = SKIP_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_AFULL = CNT_W'(AFULL_THRESH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;
  } ar_entry_t;

  ar_entry_t q      [DEPTH];
  ar_entry_t q_next [DEPTH];
  ar_entry_t in_entry;
  ar_entry_t out_entry;

  logic [CNT_W-1:0]  count_q, count_next;
  logic [SKIP_W-1:0] skip_q, skip_next;
  logic              lock_q;
  logic [IDX_W-1:0]  sel_q;
  logic              afull_q;

  logic [DEPTH-1:0][ID_WIDTH-1:0]  ids_v;
  logic [DEPTH-1:0][QOS_WIDTH-1:0] qos_v;
  logic [IDX_W-1:0] sel_comb, sel, wr_idx;
  logic in_ready, out_valid, push, pop, force_head;

  assign in_ready   = (count_q != CNT_FULL);
  assign out_valid  = (count_q != '0);
  assign push       = ar_in.valid & in_ready;
  assign pop        = out_valid & ar_out.ready;
  assign force_head = (skip_q == SKIP_MAX);

  assign in_entry = '{id:    ar_in.id,
                      addr:  ar_in.addr,
                      len:   ar_in.len,
                      size:  ar_in.size,
                      burst: ar_in.burst,
                      qos:   ar_in.qos};

  // Expose IDs and QoS values as flat vectors for the selector.
  always_comb begin
    ids_v = '0;
    qos_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ids_v[i] = q[i].id;
      qos_v[i] = q[i].qos;
    end
  end

  ar_qos_select #(
    .DEPTH     (DEPTH),
    .ID_WIDTH  (ID_WIDTH),
    .QOS_WIDTH (QOS_WIDTH),
    .MODE      (MODE)
  ) u_select (
    .ids          (ids_v),
    .qos          (qos_v),
    .count        (count_q),
    .force_head   (force_head),
    .sel          (sel_comb),
    .starve_force (starve_force)
  );

  // A request that was presented but not accepted keeps its index; existing
  // entries never move until a pop, so the locked index stays correct.
  assign sel       = lock_q ? sel_q : sel_comb;
  assign out_entry = out_valid ? q[sel] : '0;

  assign ar_in.ready  = in_ready;
  assign ar_out.valid = out_valid;
  assign ar_out.id    = out_entry.id;
  assign ar_out.addr  = out_entry.addr;
  assign ar_out.len   = out_entry.len;
  assign ar_out.size  = out_entry.size;
  assign ar_out.burst = out_entry.burst;
  assign ar_out.qos   = out_entry.qos;

  assign occupancy   = count_q;
  assign almost_full = afull_q;

  // Compact over the popped slot, then append the new request at the tail.
  always_comb begin
    q_next = q;
    wr_idx = IDX_W'(pop ? (count_q - CNT_W'(1)) : count_q);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel)) begin
          q_next[i] = q[i + 1];
        end
      end
    end
    if (push) begin
      q_next[wr_idx] = in_entry;
    end
  end

  // Occupancy and starvation-counter next state.
  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_q - CNT_W'(1);
    end
    skip_next = skip_q;
    if (pop) begin
      if (sel != '0) begin
        skip_next = (skip_q == SKIP_MAX) ? SKIP_MAX : skip_q + SKIP_W'(1);
      end else begin
        skip_next = '0;
      end
    end
    if (count_next == '0) begin
      skip_next = '0;
    end
  end

  // Entry storage needs no reset: every read is masked by count_q.
  always_ff @(posedge clk) begin
    q <= q_next;
  end

  // Control state: count, starvation counter, presentation lock, status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      skip_q  <= '0;
      lock_q  <= 1'b0;
      sel_q   <= '0;
      afull_q <= 1'b0;
    end else begin
      count_q <= count_next;
      skip_q  <= skip_next;
      afull_q <= (count_next >= CNT_AFULL);
      if (pop) begin
        lock_q <= 1'b0;
      end else if (out_valid && !ar_out.ready) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_outgoing_request_buffer_qos.sv
// Testbench: a FIFO-mode and a QoS-mode (STARVE_LIMIT=2) buffer share one
// stimulus stream; each has its own scoreboard of expected issue order.
module tb_outgoing_request_buffer_qos;

  logic clk;
  logic rst;

  logic       in_valid;
  logic [3:0] in_id;
  logic [3:0] in_qos;
  logic [31:0] in_addr;
  logic [7:0] in_len;
  logic [2:0] in_size;
  logic [1:0] in_burst;
  logic       out_ready;

  logic [3:0] fifo_occ, qos_occ;
  logic       fifo_af, qos_af, fifo_sf, qos_sf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] qos;
    logic       sf;
  } exp_t;

  exp_t exp_qos[$];
  exp_t exp_fifo[$];

  ar_if fifo_in ();
  ar_if fifo_out ();
  ar_if qos_in ();
  ar_if qos_out ();

  assign fifo_in.valid = in_valid;
  assign fifo_in.id    = in_id;
  assign fifo_in.addr  = in_addr;
  assign fifo_in.len   = in_len;
  assign fifo_in.size  = in_size;
  assign fifo_in.burst = in_burst;
  assign fifo_in.qos   = in_qos;
  assign qos_in.valid  = in_valid;
  assign qos_in.id     = in_id;
  assign qos_in.addr   = in_addr;
  assign qos_in.len    = in_len;
  assign qos_in.size   = in_size;
  assign qos_in.burst  = in_burst;
  assign qos_in.qos    = in_qos;
  assign fifo_out.ready = out_ready;
  assign qos_out.ready  = out_ready;

  outgoing_request_buffer_qos #(
    .MODE(0), .STARVE_LIMIT(4), .DEPTH(8), .AFULL_THRESH(6)
  ) dut_fifo (
    .clk          (clk),
    .rst          (rst),
    .ar_in        (fifo_in),
    .ar_out       (fifo_out),
    .occupancy    (fifo_occ),
    .almost_full  (fifo_af),
    .starve_force (fifo_sf)
  );

  outgoing_request_buffer_qos #(
    .MODE(1), .STARVE_LIMIT(2), .DEPTH(8), .AFULL_THRESH(6)
  ) dut_qos (
    .clk          (clk),
    .rst          (rst),
    .ar_in        (qos_in),
    .ar_out       (qos_out),
    .occupancy    (qos_occ),
    .almost_full  (qos_af),
    .starve_force (qos_sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload fields are a fixed function of (id, qos) so issue order can be
  // checked on the whole request, not just the ID.
  function automatic logic [44:0] mkPayload(input logic [3:0] id, input logic [3:0] qos);
    logic [31:0] a;
    a = {16'hA5A5, id, qos, 8'h3C};
    return {a, qos, id, qos[2:0] ^ 3'b101, id[1:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic v, input int id, input int qos, input logic rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_id     = 4'(id);
    in_qos    = 4'(qos);
    {in_addr, in_len, in_size, in_burst} = mkPayload(4'(id), 4'(qos));
    out_ready = rdy;
  endtask

  task automatic expectIssue(input int id, input int qos, input logic sf);
    exp_qos.push_back(exp_t'{4'(id), 4'(qos), sf});
  endtask

  // Scoreboard: compare each accepted output against the queue head; the
  // FIFO-mode expectation is simply the order of accepted inputs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (qos_out.valid && qos_out.ready) begin
        checkOutput("qos_pop_expected", 64'(exp_qos.size() != 0), 64'(1));
        if (exp_qos.size() != 0) begin
          e = exp_qos.pop_front();
          checkOutput("qos_id", 64'(qos_out.id), 64'(e.id));
          checkOutput("qos_qos", 64'(qos_out.qos), 64'(e.qos));
          checkOutput("qos_payload",
                      64'({qos_out.addr, qos_out.len, qos_out.size, qos_out.burst}),
                      64'(mkPayload(e.id, e.qos)));
          checkOutput("qos_starve_force", 64'(qos_sf), 64'(e.sf));
        end
      end
      if (fifo_out.valid && fifo_out.ready) begin
        checkOutput("fifo_pop_expected", 64'(exp_fifo.size() != 0), 64'(1));
        if (exp_fifo.size() != 0) begin
          e = exp_fifo.pop_front();
          checkOutput("fifo_id", 64'(fifo_out.id), 64'(e.id));
          checkOutput("fifo_payload",
                      64'({fifo_out.addr, fifo_out.len, fifo_out.size, fifo_out.burst}),
                      64'(mkPayload(e.id, e.qos)));
          checkOutput("fifo_starve_force", 64'(fifo_sf), 64'(0));
        end
      end
      if (fifo_in.valid && fifo_in.ready) begin
        exp_fifo.push_back(exp_t'{fifo_in.id, fifo_in.qos, 1'b0});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_id     = '0;
    in_qos    = '0;
    in_addr   = '0;
    in_len    = '0;
    in_size   = '0;
    in_burst  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 64'(qos_out.valid), 64'(0));
    checkOutput("rst_payload", 64'({qos_out.id, qos_out.addr, qos_out.len, qos_out.size,
                                    qos_out.burst, qos_out.qos}), 64'(0));
    checkOutput("rst_ready", 64'(qos_in.ready), 64'(1));
    checkOutput("rst_occ", 64'(qos_occ), 64'(0));
    checkOutput("rst_afull", 64'(qos_af), 64'(0));
    checkOutput("rst_starve", 64'(qos_sf), 64'(0));
    checkOutput("rst_fifo_valid", 64'(fifo_out.valid), 64'(0));
    rst = 1'b0;

    // QoS order behind a locked blocker; the lowest-QoS head is forced out
    // after two bypasses. FIFO mode issues in arrival order with occupancy 4..0.
    expectIssue(9, 1, 1'b0);
    expectIssue(2, 15, 1'b0);
    expectIssue(3, 7, 1'b0);
    expectIssue(1, 0, 1'b1);
    applyStimulus(1, 9, 1, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 2, 15, 0);
    applyStimulus(1, 3, 7, 0);
    applyStimulus(0, 0, 0, 1);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("t1_occ", 64'(fifo_occ), 64'(4 - k));
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("t1_qos_drained", 64'(exp_qos.size()), 64'(0));
    checkOutput("t1_fifo_drained", 64'(exp_fifo.size()), 64'(0));

    // Same-ID blocking: the q15 id5 request never passes the older id5.
    expectIssue(9, 1, 1'b0);
    expectIssue(6, 3, 1'b0);
    expectIssue(5, 0, 1'b0);
    expectIssue(5, 15, 1'b0);
    applyStimulus(1, 9, 1, 0);
    applyStimulus(1, 5, 0, 0);
    applyStimulus(1, 5, 15, 0);
    applyStimulus(1, 6, 3, 0);
    applyStimulus(0, 0, 0, 1);
    repeat (5) @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_qos_drained", 64'(exp_qos.size()), 64'(0));
    checkOutput("t2_fifo_drained", 64'(exp_fifo.size()), 64'(0));

    // Presented request holds while a higher-QoS request arrives behind it.
    expectIssue(1, 2, 1'b0);
    expectIssue(2, 15, 1'b0);
    applyStimulus(1, 1, 2, 0);
    applyStimulus(1, 2, 15, 0);
    applyStimulus(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t3_lock_id", 64'(qos_out.id), 64'(1));
      checkOutput("t3_lock_valid", 64'(qos_out.valid), 64'(1));
    end
    applyStimulus(0, 0, 0, 1);
    repeat (3) @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t3_qos_drained", 64'(exp_qos.size()), 64'(0));

    // Continuous q15 stream: id0 waits two bypasses, then is forced out.
    expectIssue(9, 1, 1'b0);
    expectIssue(10, 15, 1'b0);
    expectIssue(11, 15, 1'b0);
    expectIssue(0, 0, 1'b1);
    expectIssue(12, 15, 1'b0);
    expectIssue(13, 15, 1'b0);
    expectIssue(14, 15, 1'b0);
    applyStimulus(1, 9, 1, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 10, 15, 0);
    for (int k = 11; k <= 14; k++) begin
      applyStimulus(1, k, 15, 1);
      @(negedge clk);
      checkOutput("t4_occ", 64'(qos_occ), 64'(3));
    end
    applyStimulus(0, 0, 0, 1);
    repeat (4) @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4_qos_drained", 64'(exp_qos.size()), 64'(0));
    checkOutput("t4_fifo_drained", 64'(exp_fifo.size()), 64'(0));

    // Fill to full, reject a push during a pop when full, then reset mid-burst.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, k, 3, 0);
      @(negedge clk);
      checkOutput("t5_fill_occ", 64'(qos_occ), 64'(k));
      checkOutput("t5_fill_afull", 64'(qos_af), 64'(k >= 6));
    end
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t5_full_occ", 64'(qos_occ), 64'(8));
    checkOutput("t5_full_afull", 64'(qos_af), 64'(1));
    checkOutput("t5_full_ready", 64'(qos_in.ready), 64'(0));
    checkOutput("t5_full_ready_fifo", 64'(fifo_in.ready), 64'(0));
    expectIssue(0, 3, 1'b0);
    applyStimulus(1, 8, 3, 1);
    @(negedge clk);
    checkOutput("t5_no_passthru", 64'(qos_in.ready), 64'(0));
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t5_after_pop_occ", 64'(qos_occ), 64'(7));
    checkOutput("t5_after_pop_afull", 64'(qos_af), 64'(1));
    checkOutput("t5_after_pop_ready", 64'(qos_in.ready), 64'(1));
    expectIssue(1, 3, 1'b0);
    expectIssue(2, 3, 1'b0);
    applyStimulus(1, 8, 3, 1);
    applyStimulus(1, 9, 3, 1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("t5_rst_valid", 64'(qos_out.valid), 64'(0));
    checkOutput("t5_rst_occ", 64'(qos_occ), 64'(0));
    checkOutput("t5_rst_ready", 64'(qos_in.ready), 64'(1));
    checkOutput("t5_rst_afull", 64'(qos_af), 64'(0));
    checkOutput("t5_rst_id", 64'(qos_out.id), 64'(0));
    checkOutput("t5_rst_fifo_valid", 64'(fifo_out.valid), 64'(0));
    checkOutput("t5_rst_fifo_occ", 64'(fifo_occ), 64'(0));
    checkOutput("t5_qos_drained", 64'(exp_qos.size()), 64'(0));
    exp_fifo.delete();
    @(negedge clk);
    rst = 1'b0;

    // After reset: a push is not visible in its own cycle, issues the next.
    expectIssue(4, 4, 1'b0);
    applyStimulus(1, 4, 4, 0);
    @(negedge clk);
    checkOutput("t6_no_bypass", 64'(qos_out.valid), 64'(0));
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_valid", 64'(qos_out.valid), 64'(1));
    checkOutput("t6_id", 64'(qos_out.id), 64'(4));
    checkOutput("t6_occ", 64'(qos_occ), 64'(1));
    applyStimulus(0, 0, 0, 1);
    repeat (2) @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t6_qos_drained", 64'(exp_qos.size()), 64'(0));
    checkOutput("t6_fifo_drained", 64'(exp_fifo.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
